// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
//   uart_arb_state_t : arbiter FSM encoding
//   UART_ARB_MAX_REQ : largest supported requester count
//   wrap_inc         : round-robin index increment modulo n
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_START     = 3'd1,
        ARB_WAIT_LOW  = 3'd2,
        ARB_WAIT_HIGH = 3'd3,
        ARB_LOCKED    = 3'd4
    } uart_arb_state_t;

    localparam int UART_ARB_MAX_REQ = 8;

    // Next round-robin index after idx, wrapping at n (n <= UART_ARB_MAX_REQ).
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
        logic [3:0] sum;
        sum = {1'b0, idx} + 4'd1;
        return (int'(sum) >= n) ? 3'd0 : sum[2:0];
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin selector.
//   valid : request vector
//   ptr   : index with the highest priority this cycle
//   found : at least one request is set
//   idx   : first set index scanning upward from ptr, wrapping
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    import uart_arb_pkg::*;

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [W:0]     sum_s;
    logic           hit_s;

    // Rotate so that ptr lands at bit 0, take the first set bit, then map back.
    always_comb begin
        dbl_s = {valid, valid} >> ptr;
        rot_s = dbl_s[N-1:0];
        found = 1'b0;
        idx   = '0;
        sum_s = '0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr} + (W+1)'(k);
            sum_s = (sum_s >= (W+1)'(N)) ? (sum_s - (W+1)'(N)) : sum_s;
            hit_s = rot_s[k] & ~found;
            idx   = hit_s ? sum_s[W-1:0] : idx;
            found = found | rot_s[k];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one RS232 transmitter among NUM_REQ byte streams.
// Round-robin between packets; a winner keeps the transmitter until it sends
// a byte flagged last. A watchdog releases a stalled UART or lock owner.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/data/last, req_ready : per-requester byte handshake
//   uart_tx, uart_start_tx, uart_tx_ready : UART TX/start_TX/TX_ready
//   grant           : one-hot owner, 0 when idle
//   busy            : FSM not idle
//   timeout_err     : sticky watchdog flag
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx,
    output logic                 uart_start_tx,
    input  logic                 uart_tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    uart_arb_state_t    state_r, state_next_s;
    logic [PW-1:0]      ptr_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [7:0]         data_reg_r;
    logic               last_reg_r;
    logic [31:0]        wdog_r, wdog_next_s;
    logic               timeout_err_r;

    logic               pick_found_s;
    logic [PW-1:0]      pick_idx_s;
    logic [PW-1:0]      owner_idx_s;
    logic [PW-1:0]      ptr_after_owner_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic               load_s;
    logic [PW-1:0]      load_idx_s;
    logic               release_s;
    logic               timeout_s;
    logic               wdog_hit_s;

    // Index of the single set bit of a one-hot grant vector.
    function automatic logic [PW-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            r = oh[i] ? PW'(i) : r;
        end
        return r;
    endfunction

    rr_picker #(.N(NUM_REQ), .W(PW)) u_picker (
        .valid (req_valid),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign owner_idx_s       = onehot_idx(grant_r);
    assign ptr_after_owner_s = PW'(wrap_inc(3'(owner_idx_s), NUM_REQ));
    assign wdog_hit_s        = (wdog_r == (TIMEOUT_CYCLES - 32'd1));

    // Next-state, handshake and load/release decisions.
    always_comb begin
        state_next_s = state_r;
        req_ready_s  = '0;
        load_s       = 1'b0;
        load_idx_s   = '0;
        release_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (uart_tx_ready && pick_found_s) begin
                    req_ready_s  = ONE_HOT0 << pick_idx_s;
                    load_s       = 1'b1;
                    load_idx_s   = pick_idx_s;
                    state_next_s = ARB_START;
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_START: begin
                state_next_s = ARB_WAIT_LOW;
            end
            ARB_WAIT_LOW: begin
                if (wdog_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ARB_IDLE;
                end else if (!uart_tx_ready) begin
                    state_next_s = ARB_WAIT_HIGH;
                end else begin
                    state_next_s = ARB_WAIT_LOW;
                end
            end
            ARB_WAIT_HIGH: begin
                if (wdog_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ARB_IDLE;
                end else if (uart_tx_ready) begin
                    release_s    = last_reg_r;
                    state_next_s = last_reg_r ? ARB_IDLE : ARB_LOCKED;
                end else begin
                    state_next_s = ARB_WAIT_HIGH;
                end
            end
            ARB_LOCKED: begin
                // Watchdog wins a tie so that a timed-out owner never gets a byte in.
                if (wdog_hit_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = ARB_IDLE;
                end else if (|(req_valid & grant_r) && uart_tx_ready) begin
                    req_ready_s  = grant_r;
                    load_s       = 1'b1;
                    load_idx_s   = owner_idx_s;
                    state_next_s = ARB_START;
                end else begin
                    state_next_s = ARB_LOCKED;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    // Watchdog runs only while waiting on the UART or the lock owner.
    always_comb begin
        wdog_next_s = 32'd0;
        if (state_next_s != state_r) begin
            wdog_next_s = 32'd0;
        end else if (state_r == ARB_WAIT_LOW || state_r == ARB_WAIT_HIGH ||
                     state_r == ARB_LOCKED) begin
            wdog_next_s = wdog_r + 32'd1;
        end else begin
            wdog_next_s = 32'd0;
        end
    end

    // State, data latch, ownership, round-robin pointer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ARB_IDLE;
            ptr_r         <= '0;
            grant_r       <= '0;
            data_reg_r    <= 8'h00;
            last_reg_r    <= 1'b0;
            wdog_r        <= 32'd0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            wdog_r        <= wdog_next_s;
            timeout_err_r <= timeout_err_r | timeout_s;
            if (load_s) begin
                data_reg_r <= req_data[{load_idx_s, 3'b000} +: 8];
                last_reg_r <= req_last[load_idx_s];
                grant_r    <= ONE_HOT0 << load_idx_s;
            end else if (release_s || timeout_s) begin
                grant_r <= '0;
                ptr_r   <= ptr_after_owner_s;
            end else begin
                grant_r <= grant_r;
            end
        end
    end

    assign req_ready     = req_ready_s;
    assign uart_tx       = data_reg_r;
    assign uart_start_tx = (state_r == ARB_START);
    assign grant         = grant_r;
    assign busy          = (state_r != ARB_IDLE);
    assign timeout_err   = timeout_err_r;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single RS232 transmitter among `NUM_REQ` byte-stream requesters, such as the CPU console, the debug monitor and the DMA dump path. Arbitration is round-robin with packet locking: once a requester wins, it owns the transmitter until it sends a byte flagged `req_last`. The block sits between the requesters and the RS232 `TX`/`start_TX`/`TX_ready` handshake, and issues one single-cycle start pulse per byte. A watchdog releases the transmitter if either the UART or the lock owner stalls.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 32'd1_000_000: watchdog limit in clk cycles, must be ≥ 2.

- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  8*NUM_REQ  byte of requester i, at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte of requester i ends its packet.
- `req_ready`  out  NUM_REQ  one-hot; the byte is consumed on the cycle where `req_valid[i] && req_ready[i]`.
- `uart_tx`  out  8  byte presented to the UART `TX`.
- `uart_start_tx`  out  1  to the UART `start_TX`.
- `uart_tx_ready`  in  1  from the UART `TX_ready`.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `busy`  out  1  state != IDLE.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Registered state: `state`, `ptr` (round-robin pointer, $clog2(NUM_REQ) bits), `grant`, `data_reg[7:0]`, `last_reg`, `wdog[31:0]`, `timeout_err`.
- Winner selection: the first index with `req_valid` set, scanning from `ptr` upward and wrapping modulo NUM_REQ.
- IDLE:
  - Condition to accept: `uart_tx_ready == 1` and any `req_valid` is set.
  - `req_ready[w] = 1` combinationally for that cycle.
  - Latch `data_reg <= req_data[w]`, `last_reg <= req_last[w]`, `grant <= 1<<w`.
  - Next state: START.
- START:
  - `uart_start_tx = 1` for exactly one cycle.
  - Next state: WAIT_LOW.
- WAIT_LOW: wait for `uart_tx_ready == 0`, then go to WAIT_HIGH.
- WAIT_HIGH: wait for `uart_tx_ready == 1`.
  - If `last_reg` is set: go to IDLE, clear `grant`, `ptr <= (w+1) mod NUM_REQ`.
  - Otherwise: go to LOCKED.
- LOCKED:
  - Only the granted requester is served. Other requesters see `req_ready = 0` regardless of their `req_valid`.
  - On `req_valid[g] && uart_tx_ready`: `req_ready[g] = 1`, latch data and last, go to START.
- Watchdog:
  - `wdog` counts cycles spent in WAIT_LOW, WAIT_HIGH and LOCKED, and clears on every state change.
  - When `wdog == TIMEOUT_CYCLES - 1`: set `timeout_err`, go to IDLE, clear `grant`, advance `ptr` past the owner.
  - `timeout_err` clears only on `rst`.
- `uart_tx` is `data_reg` at all times. `uart_start_tx` is 1 only in START.
- The UART transmits LSB first, 8N1. This block does no framing.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `grant` = 0, `data_reg` = 0, `last_reg` = 0, `wdog` = 0. Outputs: `req_ready` = 0, `uart_tx` = 8'h00, `uart_start_tx` = 0, `busy` = 0, `timeout_err` = 0.
- Accept on cycle T leads to `uart_start_tx` at T+1. The UART drops `TX_ready` at T+2, and WAIT_LOW exits at T+2.
- Next accept comes at the earliest one cycle after `uart_tx_ready` returns high, from either LOCKED or IDLE.
- Sustained rate is one byte per UART frame plus 3 cycles.
- `req_valid` dropping while LOCKED is legal: the block holds the lock and keeps the watchdog running.
- Simultaneous requests in IDLE are resolved by `ptr` only. Input order never matters.
- If `rst` is asserted mid-frame, the block returns to IDLE the next cycle. Because IDLE waits for `uart_tx_ready == 1`, a frame the UART is still sending is never overrun.
- A stray `uart_tx_ready` glitch in WAIT_HIGH is taken at face value. The UART guarantees a clean level.

## Structure
- Package `uart_arb_pkg`:
  - `typedef enum logic [2:0] {ARB_IDLE, ARB_START, ARB_WAIT_LOW, ARB_WAIT_HIGH, ARB_LOCKED} uart_arb_state_t`.
  - `localparam UART_ARB_MAX_REQ = 8`.
- Sub-module `rr_picker`, parameterised by N:
  - Inputs: `valid[N]`, `ptr`.
  - Outputs: `found`, `idx`.
  - Purely combinational rotate / find-first / unrotate.
- `uart_tx_arbiter` instantiates `rr_picker`. The RS232 instance itself lives one level up.

## Test plan
- Single requester 0 sends 8'hA5 with `req_last` → exactly one `uart_start_tx` pulse, `uart_tx` = 8'hA5; `grant` returns to 0 after `TX_ready` rises; `ptr` = 1.
- Requesters 1 and 3 both valid in IDLE with `ptr` = 0 → 1 wins. On the next packet, with both still valid and `ptr` = 2, 3 wins.
- Requester 2 sends a 3-byte packet {8'h01, 8'h02, 8'h03 + last} while requester 0 stays valid → serial line shows 01, 02, 03 uninterrupted, and `req_ready[0]` stays 0 throughout.
- UART model holds `TX_ready` low forever, with `TIMEOUT_CYCLES` = 100 → `timeout_err` rises 100 cycles after entering WAIT_HIGH; state returns to IDLE and `grant` = 0.
- LOCKED owner stops asserting `req_valid` → timeout fires and releases; a different requester is then granted next.
- `rst` pulsed during WAIT_HIGH while the UART is mid-frame → outputs return to reset values; no start pulse is issued until `uart_tx_ready` = 1.
